// File: rtl/key_scheduler.sv
// key_scheduler: monophonic key controller for the piano datapath.
// Synchronizes and debounces four active-low buttons, picks one note
// (lowest index wins when a note is chosen, no preemption while held) and
// runs an attack/sustain/release amplitude envelope for it.
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous, active-high
//   keys[3:0]  raw buttons, active-low, asynchronous to clk
//   select     note code to switch stage: {4'h0, 4'hF with note bit cleared}, 8'h0F idle
//   gate       high in ATTACK and SUSTAIN
//   amplitude  envelope level 0..255
//   busy       high whenever not IDLE
`timescale 1ns/1ps

// One key lane: 2-flop synchronizer followed by a stable-count debouncer.
module key_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        // input has disagreed for CYCLES consecutive cycles: accept it
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module key_scheduler #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ATTACK_DIV      = 1024,
  parameter int RELEASE_DIV     = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keys,
  output logic [7:0] select,
  output logic       gate,
  output logic [7:0] amplitude,
  output logic       busy
);
  localparam int NUM_KEYS = 4;
  localparam int MAX_DIV  = (ATTACK_DIV > RELEASE_DIV) ? ATTACK_DIV : RELEASE_DIV;
  localparam int CW       = $clog2(MAX_DIV) + 1;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] pressed;
  logic [1:0]          lowest;

  state_t        state, state_n;
  logic [1:0]    note, note_n;
  logic [7:0]    amp_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    select_n;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (keys[k]),
      .level (level[k])
    );
  end

  assign pressed = ~level;

  // lowest pressed index; scanning downward leaves the smallest one
  always_comb begin
    lowest = 2'd0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (pressed[k]) lowest = 2'(k);
  end

  always_comb begin
    state_n = state;
    note_n  = note;
    amp_n   = amplitude;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        amp_n = 8'd0;
        if (|pressed) begin
          note_n  = lowest;
          state_n = ATTACK;
        end
      end
      ATTACK: begin
        if (cnt == CW'(ATTACK_DIV - 1)) begin
          cnt_n = '0;
          if (amplitude != 8'hFF) amp_n = amplitude + 8'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        // release wins over reaching the top in the same cycle
        if (!pressed[note])      state_n = RELEASE;
        else if (amp_n == 8'hFF) state_n = SUSTAIN;
      end
      SUSTAIN: begin
        amp_n = 8'hFF;
        if (!pressed[note]) state_n = RELEASE;
      end
      RELEASE: begin
        if (cnt == CW'(RELEASE_DIV - 1)) begin
          cnt_n = '0;
          if (amplitude != 8'h00) amp_n = amplitude - 8'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        // a new press retriggers from the current level, even one that just hit 0
        if (|pressed) begin
          note_n  = lowest;
          state_n = ATTACK;
        end else if (amp_n == 8'h00) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  assign select_n = (state_n == IDLE) ? 8'h0F : {4'h0, ~(4'b0001 << note_n)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      note      <= 2'd0;
      cnt       <= '0;
      amplitude <= 8'd0;
      select    <= 8'h0F;
      gate      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      note      <= note_n;
      cnt       <= cnt_n;
      amplitude <= amp_n;
      select    <= select_n;
      gate      <= (state_n == ATTACK) || (state_n == SUSTAIN);
      busy      <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_key_scheduler.sv
// Bench for key_scheduler with small parameters. A reference model tracks
// debounced levels and the envelope as "entry level plus elapsed time / DIV",
// and is compared against every output every cycle, alongside directed checks.
`timescale 1ns/1ps

module tb_key_scheduler;
  localparam int DB  = 4;
  localparam int ATT = 2;
  localparam int REL = 3;
  localparam int S_IDLE = 0, S_ATT = 1, S_SUS = 2, S_REL = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys;
  logic [7:0] select;
  logic       gate;
  logic [7:0] amplitude;
  logic       busy;

  int ncmp = 0;
  int nerr = 0;

  key_scheduler #(.DEBOUNCE_CYCLES(DB), .ATTACK_DIV(ATT), .RELEASE_DIV(REL)) dut (
    .clk       (clk),
    .reset     (reset),
    .keys      (keys),
    .select    (select),
    .gate      (gate),
    .amplitude (amplitude),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0] m_s1, m_s2, m_db;
  int m_run [4];
  int m_st, m_note, m_amp, m_entry, m_t;

  task automatic m_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_db = 4'hF;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
    m_st = S_IDLE; m_note = 0; m_amp = 0; m_entry = 0; m_t = 0;
  endtask

  function automatic int low_idx(input logic [3:0] p);
    for (int k = 0; k < 4; k++) if (p[k]) return k;
    return 0;
  endfunction

  task automatic m_enter(input int s, input int a);
    m_st = s; m_entry = a; m_amp = a; m_t = 0;
  endtask

  task automatic m_step();
    logic [3:0] pr;
    int a;
    pr = ~m_db;
    m_t++;
    case (m_st)
      S_IDLE: if (pr != 4'h0) begin m_note = low_idx(pr); m_enter(S_ATT, 0); end
      S_ATT: begin
        a = m_entry + m_t / ATT;
        if (a > 255) a = 255;
        if (!pr[m_note])   m_enter(S_REL, a);
        else if (a == 255) m_enter(S_SUS, 255);
        else               m_amp = a;
      end
      S_SUS: if (!pr[m_note]) m_enter(S_REL, 255);
      default: begin
        a = m_entry - m_t / REL;
        if (a < 0) a = 0;
        if (pr != 4'h0)  begin m_note = low_idx(pr); m_enter(S_ATT, a); end
        else if (a == 0) m_enter(S_IDLE, 0);
        else             m_amp = a;
      end
    endcase
    // a debounced level follows the synced input after DB consecutive disagreeing cycles
    for (int k = 0; k < 4; k++) begin
      if (m_s2[k] == m_db[k]) m_run[k] = 0;
      else begin
        m_run[k]++;
        if (m_run[k] == DB) begin m_db[k] = m_s2[k]; m_run[k] = 0; end
      end
    end
    m_s2 = m_s1;
    m_s1 = keys;
  endtask

  function automatic logic [7:0] m_sel();
    if (m_st == S_IDLE) return 8'h0F;
    return 8'h0F & ~(8'd1 << m_note);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) m_reset();
    else m_step();
    #1;
    chk("m_select", select, m_sel());
    chk("m_gate", gate, (m_st == S_ATT || m_st == S_SUS));
    chk("m_amp", amplitude, m_amp);
    chk("m_busy", busy, (m_st != S_IDLE));
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (m_st != S_IDLE && n < 5000) begin cyc(); n++; end
    chk(tag, busy, 0);
  endtask

  initial begin
    int n, hold;
    reset = 1'b1;
    keys  = 4'hF;
    m_reset();
    #2;
    chk("rst_select", select, 8'h0F);
    chk("rst_gate", gate, 0);
    chk("rst_amp", amplitude, 0);
    chk("rst_busy", busy, 0);
    run(2);
    reset = 1'b0;
    run(3);

    // single note on key 2
    keys = 4'b1011;
    run(6);
    chk("note_early_busy", busy, 0);
    run(1);
    chk("note_select", select, 8'b00001011);
    chk("note_gate", gate, 1);
    run(509);
    chk("attack_254", amplitude, 254);
    run(1);
    chk("attack_255", amplitude, 255);
    run(10);
    chk("sustain_amp", amplitude, 255);

    // release
    keys = 4'b1111;
    run(7);
    chk("rel_gate", gate, 0);
    chk("rel_select", select, 8'b00001011);
    run(764);
    chk("rel_busy_before_end", busy, 1);
    chk("rel_amp_1", amplitude, 1);
    run(1);
    chk("rel_amp_0", amplitude, 0);
    chk("rel_idle_select", select, 8'h0F);
    chk("rel_idle_busy", busy, 0);

    // priority / hold
    keys = 4'b1110;
    run(7);
    chk("hold_select0", select, 8'b00001110);
    keys = 4'b1100;
    run(20);
    chk("hold_no_preempt", select, 8'b00001110);
    keys = 4'b1111;
    wait_idle("idle_after_hold");
    keys = 4'b1100;
    run(7);
    chk("simul_key0_wins", select, 8'b00001110);

    // retrigger around amplitude 100
    run(250);
    keys = 4'b1111;
    n = 0;
    while (!(m_st == S_REL && m_amp <= 102) && n < 3000) begin cyc(); n++; end
    chk("reach_rel_100", (m_st == S_REL) ? busy : 1'b0, 1);
    keys = 4'b0111;
    run(7);
    chk("retrig_select", select, 8'b00000111);
    chk("retrig_gate", gate, 1);
    chk("retrig_amp_kept", (amplitude >= 8'd95 && amplitude <= 8'd102), 1);

    // press landing exactly on the cycle release reaches 0
    run(20);
    keys = 4'b1111;
    n = 0;
    while (!(m_st == S_REL && m_entry * REL - m_t == 7) && n < 3000) begin cyc(); n++; end
    chk("reach_zero_window", (m_st == S_REL) ? busy : 1'b0, 1);
    keys = 4'b1101;
    run(6);
    chk("zero_pre_amp", amplitude, 1);
    run(1);
    chk("zero_retrig_amp", amplitude, 0);
    chk("zero_retrig_gate", gate, 1);
    chk("zero_retrig_select", select, 8'b00001101);
    chk("zero_retrig_busy", busy, 1);
    keys = 4'b1111;
    wait_idle("idle_after_zero");

    // bounce: 3-cycle glitches on key 1
    repeat (4) begin
      keys = 4'b1101; run(3);
      keys = 4'b1111; run(3);
    end
    run(10);
    chk("bounce_select", select, 8'h0F);
    chk("bounce_busy", busy, 0);

    // asynchronous reset mid-attack
    keys = 4'b1011;
    run(30);
    chk("mid_attack_gate", gate, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_select", select, 8'h0F);
    chk("async_rst_gate", gate, 0);
    chk("async_rst_amp", amplitude, 0);
    chk("async_rst_busy", busy, 0);
    m_reset();
    run(3);
    reset = 1'b0;
    run(12);
    chk("post_rst_select", select, 8'b00001011);
    keys = 4'b1111;
    wait_idle("idle_after_rst");

    // randomized key activity
    repeat (300) begin
      keys = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom());
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 60);
      run(hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
